// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pkg                                                             |
// | Shared encodings for the RV32I multi-cycle controller and decoder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv32_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        IMM_R = 3'b000,
        IMM_I = 3'b001,
        IMM_S = 3'b010,
        IMM_B = 3'b011,
        IMM_J = 3'b100,
        IMM_U = 3'b101
    } imm_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1110
    } alu_sel_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_BUS     = 2'b10
    } trap_cause_e;

    typedef enum logic [3:0] {
        CLS_OP     = 4'd0,
        CLS_OPIMM  = 4'd1,
        CLS_LUI    = 4'd2,
        CLS_AUIPC  = 4'd3,
        CLS_LOAD   = 4'd4,
        CLS_STORE  = 4'd5,
        CLS_BRANCH = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } instr_class_e;

    // opcode[6:2]; opcode[1:0] must be 2'b11 for every 32-bit instruction
    localparam logic [4:0] c_op_load   = 5'b00000;
    localparam logic [4:0] c_op_opimm  = 5'b00100;
    localparam logic [4:0] c_op_auipc  = 5'b00101;
    localparam logic [4:0] c_op_store  = 5'b01000;
    localparam logic [4:0] c_op_op     = 5'b01100;
    localparam logic [4:0] c_op_lui    = 5'b01101;
    localparam logic [4:0] c_op_branch = 5'b11000;
    localparam logic [4:0] c_op_jalr   = 5'b11001;
    localparam logic [4:0] c_op_jal    = 5'b11011;

    function automatic alu_sel_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_sel_e sel;
        case (funct3)
            3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_decode                                                          |
// | Combinational RV32I decode: class, ALU op, immediate type, illegal.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv32_decode
    import rv32_pkg::*;
#(
    parameter int FULL_BRANCH = 1
) (
    input  logic [31:0] i_instruction,
    output logic [3:0]  o_class,
    output logic [3:0]  o_alu_sel,
    output logic [2:0]  o_imm_sel,
    output logic        o_illegal
);

    logic [4:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic         w_unused;
    instr_class_e w_class;
    alu_sel_e     w_alu;
    imm_sel_e     w_imm;
    logic         w_illegal;

    assign w_opcode = i_instruction[6:2];
    assign w_funct3 = i_instruction[14:12];
    assign w_funct7 = i_instruction[31:25];
    // register specifiers and most immediate bits never affect control
    assign w_unused = ^{i_instruction[24:15], i_instruction[11:7]};

    always_comb begin
        w_class   = CLS_OP;
        w_alu     = ALU_ADD;
        w_imm     = IMM_R;
        w_illegal = 1'b0;
        case (w_opcode)
            c_op_op: begin
                w_class = CLS_OP;
                w_alu   = alu_from_funct3(w_funct3, w_funct7[5]);
                if ((w_funct7 & 7'b101_1111) != 7'd0) begin
                    w_illegal = 1'b1;
                end
                if (w_funct7[5] && (w_funct3 != 3'b000) && (w_funct3 != 3'b101)) begin
                    w_illegal = 1'b1;
                end
            end
            c_op_opimm: begin
                w_class = CLS_OPIMM;
                w_imm   = IMM_I;
                w_alu   = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                if ((w_funct3 == 3'b001) && (w_funct7 != 7'd0)) begin
                    w_illegal = 1'b1;
                end
                if ((w_funct3 == 3'b101) && ((w_funct7 & 7'b101_1111) != 7'd0)) begin
                    w_illegal = 1'b1;
                end
            end
            c_op_lui: begin
                w_class = CLS_LUI;
                w_imm   = IMM_U;
                w_alu   = ALU_PASSB;
            end
            c_op_auipc: begin
                w_class = CLS_AUIPC;
                w_imm   = IMM_U;
            end
            c_op_load: begin
                w_class   = CLS_LOAD;
                w_imm     = IMM_I;
                w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
            end
            c_op_store: begin
                w_class   = CLS_STORE;
                w_imm     = IMM_S;
                w_illegal = w_funct3[2] || (w_funct3[1] && w_funct3[0]);
            end
            c_op_branch: begin
                w_class   = CLS_BRANCH;
                w_imm     = IMM_B;
                w_illegal = (w_funct3[2:1] == 2'b01) || ((FULL_BRANCH == 0) && w_funct3[2]);
            end
            c_op_jal: begin
                w_class = CLS_JAL;
                w_imm   = IMM_J;
            end
            c_op_jalr: begin
                w_class   = CLS_JALR;
                w_imm     = IMM_I;
                w_illegal = (w_funct3 != 3'b000);
            end
            default: w_illegal = 1'b1;
        endcase
        if (i_instruction[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end
    end

    assign o_class   = w_class;
    assign o_alu_sel = w_alu;
    assign o_imm_sel = w_imm;
    assign o_illegal = w_illegal;

endmodule
`default_nettype wire

// File: rtl/rv32_mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_mc_controller                                                   |
// | Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv32_mc_controller
    import rv32_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int FULL_BRANCH  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instruction,
    input  logic        i_BrEq,
    input  logic        i_BrLt,
    input  logic        i_mem_ack,
    output logic        o_mem_req,
    output logic        o_IRWrite,
    output logic        o_PCWrite,
    output logic        o_PCSel,
    output logic        o_BrUn,
    output logic        o_ASel,
    output logic        o_BSel,
    output logic        o_MemRW,
    output logic        o_RegWEn,
    output logic [2:0]  o_ImmSel,
    output logic [3:0]  o_ALUSel,
    output logic [1:0]  o_WBSel,
    output logic [2:0]  o_mem_size,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output logic [2:0]  o_state
);

    localparam logic [7:0] c_wait_max = 8'(MEM_WAIT_MAX);

    logic [3:0] w_class;
    logic [3:0] w_alu_sel;
    logic [2:0] w_imm_sel;
    logic       w_illegal;
    logic [2:0] w_funct3;
    logic       w_timeout;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_a_pc;
    logic       w_b_imm;
    logic       w_br_taken;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] cause_q, cause_d;

    rv32_decode #(
        .FULL_BRANCH (FULL_BRANCH)
    ) u_decode (
        .i_instruction (i_instruction),
        .o_class       (w_class),
        .o_alu_sel     (w_alu_sel),
        .o_imm_sel     (w_imm_sel),
        .o_illegal     (w_illegal)
    );

    assign w_funct3    = i_instruction[14:12];
    assign w_is_load   = (w_class == CLS_LOAD);
    assign w_is_store  = (w_class == CLS_STORE);
    assign w_is_branch = (w_class == CLS_BRANCH);
    assign w_is_jump   = (w_class == CLS_JAL) || (w_class == CLS_JALR);
    assign w_a_pc      = (w_class == CLS_AUIPC) || w_is_branch || (w_class == CLS_JAL);
    assign w_b_imm     = (w_class != CLS_OP);
    // funct3[2] selects the less-than comparator, funct3[0] inverts the sense
    assign w_br_taken  = w_funct3[2] ? (i_BrLt ^ w_funct3[0]) : (i_BrEq ^ w_funct3[0]);
    // this un-acked cycle is the last one the wait budget allows
    assign w_timeout   = ((wait_cnt_q + 8'd1) == c_wait_max);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        wait_cnt_d = 8'd0;
        case (state_q)
            S_FETCH: begin
                if (i_mem_ack) begin
                    state_d = S_DECODE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (w_timeout) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_BUS;
                    end
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_load || w_is_store) begin
                    state_d = S_MEM;
                end else if (w_is_branch) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (i_mem_ack) begin
                    state_d = w_is_load ? S_WB : S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (w_timeout) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_BUS;
                    end
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
        end
    end

    // IRWrite and the store's PC update follow the ack in the same cycle,
    // so outputs decode state plus live inputs; reset forces them all low.
    always_comb begin
        o_mem_req    = 1'b0;
        o_IRWrite    = 1'b0;
        o_PCWrite    = 1'b0;
        o_PCSel      = 1'b0;
        o_BrUn       = 1'b0;
        o_ASel       = 1'b0;
        o_BSel       = 1'b0;
        o_MemRW      = 1'b0;
        o_RegWEn     = 1'b0;
        o_ImmSel     = IMM_R;
        o_ALUSel     = ALU_ADD;
        o_WBSel      = WB_MEM;
        o_mem_size   = 3'b000;
        o_trap       = 1'b0;
        o_trap_cause = CAUSE_NONE;
        o_state      = S_FETCH;
        if (!i_rst) begin
            o_state = state_q;
            if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
                o_ALUSel = w_alu_sel;
                o_ImmSel = w_imm_sel;
                o_ASel   = w_a_pc;
                o_BSel   = w_b_imm;
            end
            case (state_q)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    o_IRWrite = i_mem_ack;
                end
                S_EXEC: begin
                    if (w_is_branch) begin
                        o_BrUn    = w_funct3[1];
                        o_PCWrite = 1'b1;
                        o_PCSel   = w_br_taken;
                    end
                end
                S_MEM: begin
                    o_mem_req  = 1'b1;
                    o_MemRW    = w_is_store;
                    o_mem_size = w_funct3;
                    o_PCWrite  = i_mem_ack && w_is_store;
                end
                S_WB: begin
                    o_RegWEn  = 1'b1;
                    o_PCWrite = 1'b1;
                    o_PCSel   = w_is_jump;
                    if (w_is_load) begin
                        o_WBSel = WB_MEM;
                    end else if (w_is_jump) begin
                        o_WBSel = WB_PC4;
                    end else begin
                        o_WBSel = WB_ALU;
                    end
                end
                S_TRAP: begin
                    o_trap       = 1'b1;
                    o_trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv32_mc_controller                                                |
// | Directed per-cycle vector table for the multi-cycle controller.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rv32_mc_controller;

    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, ST = 3'd5;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_LUI  = 32'h1234_52B7;
    localparam logic [31:0] I_BGEU = 32'h0020_F463;
    localparam logic [31:0] I_BEQ  = 32'h0000_0463;
    localparam logic [31:0] I_JAL  = 32'h0080_00EF;
    localparam logic [31:0] I_LW   = 32'h0000_2083;
    localparam logic [31:0] I_SW   = 32'h0020_A223;
    localparam logic [31:0] I_BAD  = 32'h0000_007F;
    localparam logic [31:0] I_MUL  = 32'h0220_81B3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ack, breq, brlt;
    logic [31:0] instr;

    logic        req, irw, pcw, pcs, brun, asel, bsel, memrw, regw, trap;
    logic [2:0]  imm, msz, st;
    logic [3:0]  alu;
    logic [1:0]  wb, cause;
    logic        n_req, n_irw, n_pcw, n_pcs, n_brun, n_asel, n_bsel, n_memrw, n_regw, n_trap;
    logic [2:0]  n_imm, n_msz, n_st;
    logic [3:0]  n_alu;
    logic [1:0]  n_wb, n_cause;

    rv32_mc_controller #(.MEM_WAIT_MAX(3), .FULL_BRANCH(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_instruction(instr), .i_BrEq(breq), .i_BrLt(brlt),
        .i_mem_ack(ack), .o_mem_req(req), .o_IRWrite(irw), .o_PCWrite(pcw), .o_PCSel(pcs),
        .o_BrUn(brun), .o_ASel(asel), .o_BSel(bsel), .o_MemRW(memrw), .o_RegWEn(regw),
        .o_ImmSel(imm), .o_ALUSel(alu), .o_WBSel(wb), .o_mem_size(msz), .o_trap(trap),
        .o_trap_cause(cause), .o_state(st)
    );

    rv32_mc_controller #(.MEM_WAIT_MAX(3), .FULL_BRANCH(0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_instruction(instr), .i_BrEq(breq), .i_BrLt(brlt),
        .i_mem_ack(ack), .o_mem_req(n_req), .o_IRWrite(n_irw), .o_PCWrite(n_pcw), .o_PCSel(n_pcs),
        .o_BrUn(n_brun), .o_ASel(n_asel), .o_BSel(n_bsel), .o_MemRW(n_memrw), .o_RegWEn(n_regw),
        .o_ImmSel(n_imm), .o_ALUSel(n_alu), .o_WBSel(n_wb), .o_mem_size(n_msz), .o_trap(n_trap),
        .o_trap_cause(n_cause), .o_state(n_st)
    );

    logic [26:0] act_main, act_nb;
    assign act_main = {st, req, irw, pcw, pcs, brun, asel, bsel, memrw, regw, imm, alu, wb, msz, trap, cause};
    assign act_nb   = {n_st, n_req, n_irw, n_pcw, n_pcs, n_brun, n_asel, n_bsel, n_memrw, n_regw,
                       n_imm, n_alu, n_wb, n_msz, n_trap, n_cause};

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        ack;
        logic        breq;
        logic        brlt;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [26:0] ctl(
        input logic [2:0] s, input logic rq, ir, pw, ps, bu, as, bs, mw, rw,
        input logic [2:0] im, input logic [3:0] al, input logic [1:0] w,
        input logic [2:0] ms, input logic tr, input logic [1:0] ca);
        return {s, rq, ir, pw, ps, bu, as, bs, mw, rw, im, al, w, ms, tr, ca};
    endfunction

    function automatic logic [26:0] fe(input logic ir);
        return ctl(SF, 1, ir, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 2'b00, 3'b000, 0, 2'b00);
    endfunction

    function automatic logic [26:0] idle(input logic [2:0] s);
        return ctl(s, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 2'b00, 3'b000, 0, 2'b00);
    endfunction

    function automatic logic [26:0] trp(input logic [1:0] ca);
        return ctl(ST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 2'b00, 3'b000, 1, ca);
    endfunction

    task automatic add(input logic r, input logic [31:0] in, input logic a, eq, lt, input logic [26:0] e);
        vec_t v;
        v.rst = r; v.instr = in; v.ack = a; v.breq = eq; v.brlt = lt; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [31:0] in, input logic a, eq, lt);
        @(posedge clk);
        #1;
        rst = r; instr = in; ack = a; breq = eq; brlt = lt;
        #3;
    endtask

    task automatic chk(input string nm, input int idx, input logic [26:0] got, input logic [26:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; instr = 32'd0; ack = 1'b0; breq = 1'b0; brlt = 1'b0;

        // reset holds every output low
        add(1, I_ADDI, 0, 0, 0, idle(SF));
        add(1, I_ADDI, 0, 0, 0, idle(SF));
        // addi: IRWrite cycle 1, WB cycle 4; ack held high outside FETCH/MEM is ignored
        add(0, I_ADDI, 1, 0, 0, fe(1));
        add(0, I_ADDI, 1, 0, 0, idle(SD));
        add(0, I_ADDI, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b001, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        add(0, I_ADDI, 1, 0, 0, ctl(SW, 0, 0, 1, 0, 0, 0, 1, 0, 1, 3'b001, 4'b0000, 2'b01, 3'b000, 0, 2'b00));
        // sub
        add(0, I_SUB, 1, 0, 0, fe(1));
        add(0, I_SUB, 1, 0, 0, idle(SD));
        add(0, I_SUB, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0001, 2'b00, 3'b000, 0, 2'b00));
        add(0, I_SUB, 1, 0, 0, ctl(SW, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3'b000, 4'b0001, 2'b01, 3'b000, 0, 2'b00));
        // lui
        add(0, I_LUI, 1, 0, 0, fe(1));
        add(0, I_LUI, 1, 0, 0, idle(SD));
        add(0, I_LUI, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b101, 4'b1110, 2'b00, 3'b000, 0, 2'b00));
        add(0, I_LUI, 1, 0, 0, ctl(SW, 0, 0, 1, 0, 0, 0, 1, 0, 1, 3'b101, 4'b1110, 2'b01, 3'b000, 0, 2'b00));
        // bgeu, BrLt=0: taken
        add(0, I_BGEU, 1, 0, 0, fe(1));
        add(0, I_BGEU, 1, 0, 0, idle(SD));
        add(0, I_BGEU, 1, 0, 0, ctl(SE, 0, 0, 1, 1, 1, 1, 1, 0, 0, 3'b011, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        // bgeu, BrLt=1: not taken
        add(0, I_BGEU, 1, 0, 1, fe(1));
        add(0, I_BGEU, 1, 0, 1, idle(SD));
        add(0, I_BGEU, 1, 0, 1, ctl(SE, 0, 0, 1, 0, 1, 1, 1, 0, 0, 3'b011, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        // beq, BrEq=1: taken, signed compare
        add(0, I_BEQ, 1, 1, 0, fe(1));
        add(0, I_BEQ, 1, 1, 0, idle(SD));
        add(0, I_BEQ, 1, 1, 0, ctl(SE, 0, 0, 1, 1, 0, 1, 1, 0, 0, 3'b011, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        // jal
        add(0, I_JAL, 1, 0, 0, fe(1));
        add(0, I_JAL, 1, 0, 0, idle(SD));
        add(0, I_JAL, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b100, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        add(0, I_JAL, 1, 0, 0, ctl(SW, 0, 0, 1, 1, 0, 1, 1, 0, 1, 3'b100, 4'b0000, 2'b10, 3'b000, 0, 2'b00));
        // lw, zero wait: 5 cycles
        add(0, I_LW, 1, 0, 0, fe(1));
        add(0, I_LW, 1, 0, 0, idle(SD));
        add(0, I_LW, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b001, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        add(0, I_LW, 1, 0, 0, ctl(SM, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3'b001, 4'b0000, 2'b00, 3'b010, 0, 2'b00));
        add(0, I_LW, 1, 0, 0, ctl(SW, 0, 0, 1, 0, 0, 0, 1, 0, 1, 3'b001, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        // sw, zero wait: 4 cycles
        add(0, I_SW, 1, 0, 0, fe(1));
        add(0, I_SW, 1, 0, 0, idle(SD));
        add(0, I_SW, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b010, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        add(0, I_SW, 1, 0, 0, ctl(SM, 1, 0, 1, 0, 0, 0, 1, 1, 0, 3'b010, 4'b0000, 2'b00, 3'b010, 0, 2'b00));
        // sw, ack withheld: three request cycles then bus trap
        add(0, I_SW, 1, 0, 0, fe(1));
        add(0, I_SW, 1, 0, 0, idle(SD));
        add(0, I_SW, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b010, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        for (int k = 0; k < 3; k++)
            add(0, I_SW, 0, 0, 0, ctl(SM, 1, 0, 0, 0, 0, 0, 1, 1, 0, 3'b010, 4'b0000, 2'b00, 3'b010, 0, 2'b00));
        add(0, I_SW, 0, 0, 0, trp(2'b10));
        add(0, I_SW, 0, 0, 0, fe(0));
        // sw, ack arrives on the last allowed cycle: completes normally
        add(0, I_SW, 1, 0, 0, fe(1));
        add(0, I_SW, 1, 0, 0, idle(SD));
        add(0, I_SW, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b010, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        add(0, I_SW, 0, 0, 0, ctl(SM, 1, 0, 0, 0, 0, 0, 1, 1, 0, 3'b010, 4'b0000, 2'b00, 3'b010, 0, 2'b00));
        add(0, I_SW, 0, 0, 0, ctl(SM, 1, 0, 0, 0, 0, 0, 1, 1, 0, 3'b010, 4'b0000, 2'b00, 3'b010, 0, 2'b00));
        add(0, I_SW, 1, 0, 0, ctl(SM, 1, 0, 1, 0, 0, 0, 1, 1, 0, 3'b010, 4'b0000, 2'b00, 3'b010, 0, 2'b00));
        // unknown opcode 0x7F: illegal trap, no writes
        add(0, I_BAD, 1, 0, 0, fe(1));
        add(0, I_BAD, 1, 0, 0, idle(SD));
        add(0, I_BAD, 1, 0, 0, trp(2'b01));
        // fetch timeout after a trap (counter restarts from 0)
        for (int k = 0; k < 3; k++)
            add(0, I_MUL, 0, 0, 0, fe(0));
        add(0, I_MUL, 0, 0, 0, trp(2'b10));
        // M-extension encoding is illegal here
        add(0, I_MUL, 1, 0, 0, fe(1));
        add(0, I_MUL, 1, 0, 0, idle(SD));
        add(0, I_MUL, 1, 0, 0, trp(2'b01));
        // reset in the middle of a lw memory phase
        add(0, I_LW, 1, 0, 0, fe(1));
        add(0, I_LW, 1, 0, 0, idle(SD));
        add(0, I_LW, 1, 0, 0, ctl(SE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b001, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        add(0, I_LW, 0, 0, 0, ctl(SM, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3'b001, 4'b0000, 2'b00, 3'b010, 0, 2'b00));
        add(1, I_LW, 0, 0, 0, idle(SF));
        add(1, I_LW, 0, 0, 0, idle(SF));
        add(0, I_LW, 0, 0, 0, fe(0));
        add(0, I_LW, 1, 0, 0, fe(1));
        add(0, I_LW, 1, 0, 0, idle(SD));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].instr, vecs[i].ack, vecs[i].breq, vecs[i].brlt);
            chk("vec", i, act_main, vecs[i].exp);
        end

        // FULL_BRANCH=0 instance: bgeu must trap as illegal after DECODE
        drive(1, I_BGEU, 0, 0, 0);
        drive(1, I_BGEU, 0, 0, 0);
        drive(0, I_BGEU, 1, 0, 0);
        chk("nb_fetch", 0, act_nb, fe(1));
        drive(0, I_BGEU, 1, 0, 0);
        chk("nb_decode", 1, act_nb, idle(SD));
        drive(0, I_BGEU, 1, 0, 0);
        chk("nb_trap", 2, act_nb, trp(2'b01));
        chk("fb_exec", 2, act_main,
            ctl(SE, 0, 0, 1, 1, 1, 1, 1, 0, 0, 3'b011, 4'b0000, 2'b00, 3'b000, 0, 2'b00));
        drive(0, I_BGEU, 0, 0, 0);
        chk("nb_refetch", 3, act_nb, fe(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
